fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of pc_register. Consumes the current pc, issues one

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, registered instruction to decode.
// Optional watchdog on WAIT/DRAIN enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int              XLEN           = 32,
  parameter int              ILEN           = 32,
  parameter logic [ILEN-1:0] NOP_INSTR      = 32'h00000013,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            pc_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic            instr_valid_q, instr_valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fault_q, fault_d;

  logic misaligned, req_fire, accept, timeout;

  assign misaligned = |pc[1:0];
  assign req_fire   = (state_q == S_REQ) && !misaligned && imem_req_ready;
  assign accept     = (state_q == S_HOLD) && instr_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  assign timeout = (wd_q == WD_W'(TIMEOUT_CYCLES));

  // Counter restarts on every entry into WAIT/DRAIN, including WAIT -> DRAIN.
  always_comb begin
    wd_d = '0;
    if ((state_d == S_WAIT || state_d == S_DRAIN) && state_d == state_q)
      wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  logic unused_timeout_cfg;
  // Without the watchdog, TIMEOUT_CYCLES has no effect.
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // pc_en must pulse in the same cycle the instruction is taken or the redirect is seen.
  assign pc_en          = (state_q != S_IDLE) && (flush || accept);
  assign imem_req_valid = (state_q == S_REQ) && !misaligned;
  assign imem_req_addr  = (state_q == S_REQ) ? pc : '0;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign fault          = fault_q;

  always_comb begin
    state_d       = state_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_d       = fault_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (misaligned && !flush) begin
          instr_valid_d = 1'b1;
          fault_d       = 1'b1;
          instr_d       = NOP_INSTR;
          instr_pc_d    = pc;
          state_d       = S_HOLD;
        end else if (req_fire) begin
          instr_pc_d = pc;
          state_d    = flush ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (flush) begin
            state_d = S_REQ;
          end else begin
            instr_d       = imem_rsp_data;
            instr_valid_d = 1'b1;
            fault_d       = 1'b0;
            state_d       = S_HOLD;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end else if (timeout) begin
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b1;
          fault_d       = 1'b1;
          state_d       = S_HOLD;
        end
      end
      // The in-flight response is dropped; a flush here only moves pc.
      S_DRAIN: if (imem_rsp_valid || timeout) state_d = S_REQ;
      S_HOLD: begin
        if (flush || instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a pc/memory model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, flush, pc_en;
  logic [31:0] pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        instr_valid, instr_ready, fault;
  logic [31:0] instr, instr_pc;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_en(pc_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Holds reset, releases it, and returns at the first negedge in the request state.
  task automatic rst_start(input logic [31:0] p);
    rst = 1'b1; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; instr_ready = 1'b0; pc = p;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1234; instr_ready = 1'b1; pc = 32'h40;
    @(negedge clk); #1;
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL rst_pc_en got %b exp 0", pc_en); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    tests++; if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL rst_req_addr got %h exp 0", imem_req_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
    tests++; if (instr !== NOP) begin fails++; $display("FAIL rst_instr got %h exp %h", instr, NOP); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL rst_fault got %b exp 0", fault); end
    @(negedge clk);
    rst = 1'b0; #1;
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL idle_flush_pc_en got %b exp 0", pc_en); end
  endtask

  task automatic test_basic_and_backpressure();
    int pulses = 0;
    rst_start(32'h0);
    imem_req_ready = 1'b1; instr_ready = 1'b1; #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++;
      $display("FAIL basic_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_req_addr); end
    pulses += int'(pc_en);
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093; #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", instr_valid); end
    pulses += int'(pc_en);
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h00500093 || instr_pc !== 32'h0 || fault !== 1'b0) begin fails++;
      $display("FAIL basic_instr got v=%b i=%h pc=%h f=%b exp v=1 i=00500093 pc=0 f=0", instr_valid, instr, instr_pc, fault); end
    pulses += int'(pc_en);
    @(negedge clk);
    pc = 32'h4; instr_ready = 1'b0; imem_req_ready = 1'b1; #1;
    pulses += int'(pc_en);
    tests++; if (pulses !== 1) begin fails++; $display("FAIL basic_pc_en_pulses got %0d exp 1", pulses); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin fails++;
      $display("FAIL bp_req got v=%b a=%h exp v=1 a=4", imem_req_valid, imem_req_addr); end
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A00113;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++; if (instr_valid !== 1'b1 || instr !== 32'h00A00113 || instr_pc !== 32'h4 || pc_en !== 1'b0) begin fails++;
        $display("FAIL bp_hold[%0d] got v=%b i=%h pc=%h en=%b exp v=1 i=00a00113 pc=4 en=0", i, instr_valid, instr, instr_pc, pc_en); end
      @(negedge clk);
    end
    instr_ready = 1'b1; #1;
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL bp_accept_pc_en got %b exp 1", pc_en); end
    @(negedge clk);
    instr_ready = 1'b0; pc = 32'h8; #1;
    tests++; if (pc_en !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || instr_valid !== 1'b0) begin fails++;
      $display("FAIL bp_next_req got en=%b v=%b a=%h iv=%b exp en=0 v=1 a=8 iv=0", pc_en, imem_req_valid, imem_req_addr, instr_valid); end
  endtask

  task automatic test_misaligned();
    rst_start(32'h6);
    imem_req_ready = 1'b1; #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL mis_req_valid got %b exp 0", imem_req_valid); end
    @(negedge clk); #1;
    tests++; if (instr_valid !== 1'b1 || fault !== 1'b1 || instr !== NOP || instr_pc !== 32'h6 || imem_req_valid !== 1'b0) begin fails++;
      $display("FAIL mis_fault got v=%b f=%b i=%h pc=%h rv=%b exp v=1 f=1 i=00000013 pc=6 rv=0", instr_valid, fault, instr, instr_pc, imem_req_valid); end
  endtask

  task automatic test_flush_wait();
    rst_start(32'h8);
    imem_req_ready = 1'b1; #1;
    @(negedge clk);
    imem_req_ready = 1'b0; flush = 1'b1; #1;
    tests++; if (pc_en !== 1'b1) begin fails++; $display("FAIL flush_pc_en got %b exp 1", pc_en); end
    @(negedge clk);
    flush = 1'b0; pc = 32'h100; #1;
    tests++; if (pc_en !== 1'b0 || imem_req_valid !== 1'b0) begin fails++;
      $display("FAIL drain_quiet got en=%b v=%b exp en=0 v=0", pc_en, imem_req_valid); end
    @(negedge clk);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; #1;
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || instr_valid !== 1'b0) begin fails++;
      $display("FAIL flush_new_req got v=%b a=%h iv=%b exp v=1 a=100 iv=0", imem_req_valid, imem_req_addr, instr_valid); end
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100073;
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h00100073 || instr_pc !== 32'h100) begin fails++;
      $display("FAIL flush_refetch got v=%b i=%h pc=%h exp v=1 i=00100073 pc=100", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_reset_mid_wait();
    rst_start(32'h20);
    imem_req_ready = 1'b1; #1;
    @(negedge clk);
    imem_req_ready = 1'b0; #1;
    rst = 1'b1; #1;
    tests++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || pc_en !== 1'b0 ||
                 instr !== NOP || instr_pc !== 32'h0 || fault !== 1'b0) begin fails++;
      $display("FAIL midrst_outputs got iv=%b rv=%b a=%h en=%b i=%h pc=%h f=%b", instr_valid, imem_req_valid, imem_req_addr, pc_en, instr, instr_pc, fault); end
    @(negedge clk);
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000BAD; #1;
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    tests++; if (instr_valid !== 1'b0 || instr !== NOP || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h20) begin fails++;
      $display("FAIL midrst_restart got iv=%b i=%h rv=%b a=%h exp iv=0 i=00000013 rv=1 a=20", instr_valid, instr, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_timeout();
    int n = 0;
    rst_start(32'h40);
    imem_req_ready = 1'b1; #1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      #1;
      if (instr_valid) begin n = i; break; end
      @(negedge clk);
    end
`ifdef FETCH_TIMEOUT_EN
    tests++; if (n < 16 || n > 18 || fault !== 1'b1 || instr !== NOP) begin fails++;
      $display("FAIL timeout_fault got cycles=%0d f=%b i=%h exp cycles=16..18 f=1 i=00000013", n, fault, instr); end
`else
    tests++; if (n !== 0) begin fails++; $display("FAIL no_timeout got valid after %0d cycles exp none", n); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00300193;
    @(negedge clk);
    imem_rsp_valid = 1'b0; #1;
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h00300193 || fault !== 1'b0) begin fails++;
      $display("FAIL slow_rsp got v=%b i=%h f=%b exp v=1 i=00300193 f=0", instr_valid, instr, fault); end
`endif
  endtask

  // Random run: the bench acts as pc_register and imem. Every accepted instruction must be
  // the memory word (or fault) for the pc the bench is currently holding.
  task automatic test_random();
    logic [31:0] pcm, tgt, rsp_addr, p_instr, p_pc;
    logic        pending, ph, accepted_now;
    int          cnt, accepted;
    pcm = 32'h0; pending = 1'b0; ph = 1'b0; cnt = 0; accepted = 0;
    p_instr = '0; p_pc = '0; rsp_addr = '0;
    rst_start(pcm);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flush          = ($urandom_range(0, 15) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      tgt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      imem_rsp_valid = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(rsp_addr); pending = 1'b0;
        end
      end
      #1;
      tests++; if (pc_en !== (flush || (instr_valid && instr_ready))) begin fails++;
        $display("FAIL rnd_pc_en cyc=%0d got %b exp %b", cyc, pc_en, flush || (instr_valid && instr_ready)); end
      if (ph) begin
        tests++; if (instr_valid !== 1'b1 || instr !== p_instr || instr_pc !== p_pc) begin fails++;
          $display("FAIL rnd_stable cyc=%0d got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", cyc, instr_valid, instr, instr_pc, p_instr, p_pc); end
      end
      accepted_now = instr_valid && instr_ready && !flush;
      if (accepted_now) begin
        accepted++;
        tests++; if (instr_pc !== pcm || fault !== (pcm[1:0] != 2'b00) ||
                     instr !== ((pcm[1:0] != 2'b00) ? NOP : mem_word(pcm))) begin fails++;
          $display("FAIL rnd_accept cyc=%0d got i=%h pc=%h f=%b for pc=%h exp i=%h", cyc, instr, instr_pc, fault, pcm,
                   (pcm[1:0] != 2'b00) ? NOP : mem_word(pcm)); end
      end
      if (imem_req_valid) begin
        tests++; if (imem_req_addr !== pcm || pcm[1:0] != 2'b00 || pending) begin fails++;
          $display("FAIL rnd_req cyc=%0d got a=%h pending=%b exp a=%h aligned, none pending", cyc, imem_req_addr, pending, pcm); end
        if (imem_req_ready) begin
          pending = 1'b1; cnt = $urandom_range(1, 3); rsp_addr = pcm;
        end
      end
      ph = instr_valid && !instr_ready && !flush;
      p_instr = instr; p_pc = instr_pc;
      if (pc_en) pcm = flush ? tgt : pcm + 32'd4;
      @(posedge clk); #1;
      pc = pcm;
      @(negedge clk);
    end
    tests++; if (accepted < 50) begin fails++; $display("FAIL rnd_progress got %0d accepted exp >=50", accepted); end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_and_backpressure();
    test_misaligned();
    test_flush_wait();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
